// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480 raster counters with sync/blank decode and a
// PIPE_DELAY-deep delay on hs/vs/blank_d to line up with registered RGB.
module vga_timing_gen #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int PIPE_DELAY = 2
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       blank_d,
  output logic       hs,
  output logic       vs,
  output logic       frame_start,
  output logic       vblank_start,
  output logic [7:0] frame_count
);
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam logic [10:0] H_VIS = 11'(H_VISIBLE);
  localparam logic [10:0] H_SS  = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] H_SE  = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] V_VIS = 11'(V_VISIBLE);
  localparam logic [10:0] V_SS  = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] V_SE  = 11'(V_VISIBLE + V_FRONT + V_SYNC);
  logic [9:0] x_q, x_d, y_q, y_d;
  logic [7:0] fc_q, fc_d;
  logic       x_end, y_end, hs_raw, vs_raw;
  always_comb begin
    x_end = x_q == 10'(H_TOTAL - 1);
    y_end = y_q == 10'(V_TOTAL - 1);
    x_d   = x_end ? 10'd0 : x_q + 10'd1;
    y_d   = x_end ? (y_end ? 10'd0 : y_q + 10'd1) : y_q;
    fc_d  = (x_end && y_end) ? fc_q + 8'd1 : fc_q;
  end
  always_ff @(posedge vga_clk or negedge reset_n)
    if (!reset_n) begin
      x_q  <= '0;
      y_q  <= '0;
      fc_q <= '0;
    end else begin
      x_q  <= x_d;
      y_q  <= y_d;
      fc_q <= fc_d;
    end
  always_comb begin
    blank        = ({1'b0, x_q} < H_VIS) && ({1'b0, y_q} < V_VIS);
    hs_raw       = !(({1'b0, x_q} >= H_SS) && ({1'b0, x_q} < H_SE));
    vs_raw       = !(({1'b0, y_q} >= V_SS) && ({1'b0, y_q} < V_SE));
    frame_start  = (x_q == 10'd0) && (y_q == 10'd0);
    vblank_start = (x_q == 10'd0) && ({1'b0, y_q} == V_VIS);
  end
  assign DrawX       = x_q;
  assign DrawY       = y_q;
  assign frame_count = fc_q;
  // Each stage carries {blank, hs, vs}; idle value keeps syncs inactive after reset.
  generate
    if (PIPE_DELAY == 0) begin : g_direct
      assign {blank_d, hs, vs} = {blank, hs_raw, vs_raw};
    end else begin : g_pipe
      logic [PIPE_DELAY-1:0][2:0] p_q, p_d;
      always_comb begin
        p_d    = p_q;
        p_d[0] = {blank, hs_raw, vs_raw};
        for (int i = 1; i < PIPE_DELAY; i++) p_d[i] = p_q[i-1];
      end
      always_ff @(posedge vga_clk or negedge reset_n)
        if (!reset_n) p_q <= {PIPE_DELAY{3'b011}};
        else p_q <= p_d;
      assign {blank_d, hs, vs} = p_q[PIPE_DELAY-1];
    end
  endgenerate
endmodule
